// File: rtl/data_memory_responder_pkg.sv
// rtl/data_memory_responder_pkg.sv - shared state encoding, legal store masks and depth default
// Imported by the responder, its interface and its storage.
package data_memory_responder_pkg;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 4096;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [3:0] MASK_BYTE0 = 4'b0001;
  localparam logic [3:0] MASK_BYTE1 = 4'b0010;
  localparam logic [3:0] MASK_BYTE2 = 4'b0100;
  localparam logic [3:0] MASK_BYTE3 = 4'b1000;
  localparam logic [3:0] MASK_HALF0 = 4'b0011;
  localparam logic [3:0] MASK_HALF1 = 4'b1100;
  localparam logic [3:0] MASK_WORD  = 4'b1111;

  // A store mask is legal only if it is one of the shapes above and its lowest set lane is the byte offset.
  function automatic logic store_mask_ok(input logic [3:0] mask, input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (mask)
      MASK_BYTE0: ok = (offset == 2'd0);
      MASK_BYTE1: ok = (offset == 2'd1);
      MASK_BYTE2: ok = (offset == 2'd2);
      MASK_BYTE3: ok = (offset == 2'd3);
      MASK_HALF0: ok = (offset == 2'd0);
      MASK_HALF1: ok = (offset == 2'd2);
      MASK_WORD:  ok = (offset == 2'd0);
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// rtl/data_memory_responder_if.sv - request/response bus between a requester and the data memory
// master drives requests and consumes responses; slave is the memory side.
interface data_memory_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [3:0]  req_write_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_read_data;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_address, req_write_data, req_write_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_read_data, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_address, req_write_data, req_write_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_read_data, rsp_error
  );

endinterface

// File: rtl/data_memory_bram.sv
// rtl/data_memory_bram.sv - single-port word memory with byte write enables
// One-cycle registered read; contents are never reset.
module data_memory_bram
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:DEPTH_WORDS-1];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - one-outstanding-request data memory with byte-lane stores and error checks
// IDLE accepts, ACCESS performs the memory operation, RESPOND holds the answer until consumed.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                          clk,
  input  logic                          reset_n,
  data_memory_responder_if.slave        bus
);

  localparam int unsigned ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_rsp_error;

  logic        w_accept;
  logic        w_out_of_range;
  logic        w_bad_mask;
  logic        w_error;
  logic        w_mem_en;
  logic [3:0]  w_mem_we;
  logic [31:0] w_mem_rdata;

  assign w_accept       = bus.req_valid && (r_state == IDLE);
  assign w_out_of_range = (r_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_bad_mask     = r_write && !store_mask_ok(r_mask, r_addr[1:0]);
  assign w_error        = w_out_of_range || w_bad_mask;

  // Write enable is qualified by ACCESS so an async reset mid-access commits nothing.
  assign w_mem_en = (r_state == ACCESS);
  assign w_mem_we = (w_mem_en && r_write && !w_error) ? r_mask : 4'b0000;

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          w_next = ACCESS;
        end
      end
      ACCESS: begin
        w_next = RESPOND;
      end
      RESPOND: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_mask      <= 4'b0000;
      r_rsp_error <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= bus.req_write;
        r_addr  <= bus.req_address;
        r_wdata <= bus.req_write_data;
        r_mask  <= bus.req_write_mask;
      end
      if (r_state == ACCESS) begin
        r_rsp_error <= w_error;
      end
    end
  end

  data_memory_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_bram (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // The RAM output is untouched while in RESPOND, so the gated view below stays stable.
  assign bus.rsp_read_data = (r_state == RESPOND && !r_write && !r_rsp_error)
                             ? (w_mem_rdata >> {r_addr[1:0], 3'b000}) : 32'h0;
  assign bus.rsp_error     = (r_state == RESPOND) ? r_rsp_error : 1'b0;

endmodule
